// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the port arbiter and the single-ported memory.
// The slave modport is the arbiter's view; master is the requester-plus-memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              fetch_req_i;
    logic [DATA_W-1:0] fetch_addr_i;
    logic              fetch_ack_o;
    logic [DATA_W-1:0] fetch_rdata_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [DATA_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic [3:0]        data_be_i;
    logic              data_ack_o;
    logic [DATA_W-1:0] data_rdata_o;

    logic              flush_i;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              busy_o;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        output fetch_ack_o, fetch_rdata_o,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
        output data_ack_o, data_rdata_o,
        input  flush_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output busy_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        input  fetch_ack_o, fetch_rdata_o,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
        input  data_ack_o, data_rdata_o,
        output flush_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage, one
// transaction at a time; data wins ties until fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = fetch owns the transaction
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;

    logic fetch_elig;
    logic flush_fetch;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;

        bus.fetch_ack_o   = 1'b0;
        bus.fetch_rdata_o = '0;
        bus.data_ack_o    = 1'b0;
        bus.data_rdata_o  = '0;
        bus.mem_req_o     = 1'b0;
        bus.mem_we_o      = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_wdata_o   = '0;
        bus.mem_be_o      = 4'h0;
        bus.busy_o        = (state_q != IDLE);

        fetch_elig  = bus.fetch_req_i & ~bus.flush_i;
        flush_fetch = bus.flush_i & owner_q;

        case (state_q)
            IDLE: begin
                // Data wins unless fetch is eligible and has already been passed over LIMIT times
                if (bus.data_req_i && !(fetch_elig && starve_q == LIMIT)) begin
                    state_d  = ISSUE;
                    owner_d  = 1'b0;
                    addr_d   = bus.data_addr_i;
                    we_d     = bus.data_we_i;
                    wdata_d  = bus.data_wdata_i;
                    be_d     = bus.data_be_i;
                    if (!fetch_elig)
                        starve_d = '0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + CNT_W'(1);
                end else if (fetch_elig) begin
                    state_d  = ISSUE;
                    owner_d  = 1'b1;
                    addr_d   = bus.fetch_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = 4'hF;
                    starve_d = '0;
                end
            end
            ISSUE: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_addr_o  = addr_q;
                bus.mem_wdata_o = wdata_q;
                bus.mem_be_o    = be_q;
                if (flush_fetch)
                    drop_d = 1'b1;
                if (bus.mem_ready_i)
                    state_d = WAIT;
            end
            WAIT: begin
                if (flush_fetch)
                    drop_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving with the response itself also kills the fetch ack
                    if (owner_q) begin
                        bus.fetch_ack_o = ~(drop_q | bus.flush_i);
                        if (bus.fetch_ack_o)
                            bus.fetch_rdata_o = bus.mem_rdata_i;
                    end else begin
                        bus.data_ack_o   = 1'b1;
                        bus.data_rdata_o = bus.mem_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= 4'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end
endmodule
